// File: rtl/wb_ram_sync_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : wb_ram_sync_if                                             |
// | Purpose : Wishbone bus bundle between the memory-stage master and    |
// |           the wb_ram_sync slave RAM.                                  |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface wb_ram_sync_if #(
  parameter int ADDR_W = 32
);
  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        width;
  logic [31:0]       data_write;
  logic [31:0]       data_read;
  logic              ack;
  logic              err;

  modport master (
    output cyc, stb, we, addr, width, data_write,
    input  data_read, ack, err
  );

  modport slave (
    input  cyc, stb, we, addr, width, data_write,
    output data_read, ack, err
  );
endinterface
`default_nettype wire

// File: rtl/wb_ram_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : wb_ram_sync                                                |
// | Purpose : Byte-addressed Wishbone slave RAM with registered reads,   |
// |           programmable wait states and a one-cycle ack pulse.        |
// |           Build macro WBRAM_ERR_EN: misaligned / out-of-range        |
// |           accesses answer with err instead of being performed.       |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module wb_ram_sync #(
  parameter int SIZE        = 4096,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic          iClk,
  input  logic          iRst,
  wb_ram_sync_if.slave  bus
);

  localparam int c_AW   = $clog2(SIZE);
  localparam int c_ROWS = SIZE / 4;
  localparam int c_RW   = (c_AW > 2) ? c_AW - 2 : 1;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_WAIT = 2'd1;
  localparam logic [1:0] c_ST_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [1:0]        width_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;

  logic              w_idle;
  logic              w_accept;
  logic              w_commit;
  logic              w_req_we;
  logic [1:0]        w_req_width;
  logic [ADDR_W-1:0] w_req_addr;
  logic [31:0]       w_req_wdata;
  logic [2:0]        w_nbytes;
  logic              w_req_err;

  logic [31:0]       w_rd_word;
  logic [63:0]       w_rd_dbl;
  logic [31:0]       w_rot;
  logic [31:0]       w_mask;
  logic              w_ack;
  logic              w_err;
  logic [31:0]       w_data;

  assign w_idle   = (state_q == c_ST_IDLE);
  assign w_accept = w_idle & bus.cyc & bus.stb;
  // The commit edge is the one entering RESP; reset overrides it.
  assign w_commit = (state_d == c_ST_RESP) & ~iRst;

  // With zero wait states the commit edge is also the accept edge, so the
  // live bus values must be used; otherwise the latched copy is used.
  assign w_req_we    = w_idle ? bus.we         : we_q;
  assign w_req_width = w_idle ? bus.width      : width_q;
  assign w_req_addr  = w_idle ? bus.addr       : addr_q;
  assign w_req_wdata = w_idle ? bus.data_write : wdata_q;

  assign w_nbytes = w_req_width[1] ? 3'd4 : (w_req_width[0] ? 3'd2 : 3'd1);

`ifdef WBRAM_ERR_EN
  logic              w_misalign;
  logic [ADDR_W:0]   w_last;
  assign w_misalign = (~w_req_width[1] & w_req_width[0] & w_req_addr[0]) |
                      (w_req_width[1] & (|w_req_addr[1:0]));
  // Address of the last byte touched, one bit wider so it cannot overflow.
  assign w_last     = {1'b0, w_req_addr} + {{(ADDR_W-2){1'b0}}, w_nbytes}
                      - (ADDR_W+1)'(1);
  assign w_req_err  = w_misalign | (w_last >= (ADDR_W+1)'(SIZE));
`else
  logic w_unused_addr;
  // Upper address bits are don't-care: addresses wrap modulo SIZE.
  assign w_unused_addr = ^w_req_addr;
  assign w_req_err     = 1'b0;
`endif

  // Four byte-wide banks indexed by address[1:0]; any access of up to four
  // consecutive bytes touches each bank at most once, even when misaligned.
  for (genvar b = 0; b < 4; b++) begin : g_bank
    logic [1:0]      w_k;
    logic            w_en;
    logic [c_AW+1:0] w_lin;
    logic [c_RW-1:0] w_row;
    logic [7:0]      w_wbyte;
    logic [7:0]      mem [c_ROWS];
    logic [7:0]      rd_q;

    // Byte lane k of the access that lands in this bank.
    assign w_k     = 2'(b) - w_req_addr[1:0];
    assign w_en    = ({1'b0, w_k} < w_nbytes);
    assign w_lin   = ({2'b00, w_req_addr[c_AW-1:0]} + {{c_AW{1'b0}}, w_k})
                     & (c_AW+2)'(SIZE-1);
    assign w_row   = c_RW'(w_lin >> 2);
    assign w_wbyte = w_req_wdata[{w_k, 3'b000} +: 8];

    // Storage write at the commit edge; contents survive reset.
    always_ff @(posedge iClk) begin
      if (w_commit && w_req_we && !w_req_err && w_en) begin
        mem[w_row] <= w_wbyte;
      end
    end

    // Registered read port sampled at the commit edge.
    always_ff @(posedge iClk) begin
      if (iRst) begin
        rd_q <= '0;
      end else if (w_commit && !w_req_we) begin
        rd_q <= mem[w_row];
      end
    end

    assign w_rd_word[8*b +: 8] = rd_q;
  end

  // Rotate bank order back into lane order using the latched low address.
  assign w_rd_dbl = {w_rd_word, w_rd_word};
  assign w_rot    = w_rd_dbl[{addr_q[1:0], 3'b000} +: 32];
  assign w_mask   = width_q[1] ? 32'hFFFF_FFFF :
                    (width_q[0] ? 32'h0000_FFFF : 32'h0000_00FF);

  // Request latch, wait counter and error flag.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      width_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (w_accept) begin
        we_q    <= bus.we;
        width_q <= bus.width;
        addr_q  <= bus.addr;
        wdata_q <= bus.data_write;
        cnt_q   <= 4'(WAIT_STATES);
      end else if (state_q == c_ST_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (w_commit) begin
        err_q <= w_req_err;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; dropping cyc during WAIT abandons the request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: begin
        if (bus.cyc && bus.stb) begin
          state_d = (WAIT_STATES > 0) ? c_ST_WAIT : c_ST_RESP;
        end
      end
      c_ST_WAIT: begin
        if (!bus.cyc) begin
          state_d = c_ST_IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = c_ST_RESP;
        end
      end
      c_ST_RESP: state_d = c_ST_IDLE;
      default:   state_d = c_ST_IDLE;
    endcase
  end

  // FSM outputs: one-cycle ack or err in RESP, read data only with ack.
  always_comb begin
    w_ack  = 1'b0;
    w_err  = 1'b0;
    w_data = '0;
    if (state_q == c_ST_RESP) begin
      if (err_q) begin
        w_err = 1'b1;
      end else begin
        w_ack = 1'b1;
        if (!we_q) begin
          w_data = w_rot & w_mask;
        end
      end
    end
  end

  assign bus.ack       = w_ack;
  assign bus.err       = w_err;
  assign bus.data_read = w_data;

endmodule
`default_nettype wire

// File: tb/tb_wb_ram_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_wb_ram_sync                                             |
// | Purpose : Directed, table-driven bench for wb_ram_sync (zero and     |
// |           three wait-state instances). Honours WBRAM_ERR_EN.         |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_wb_ram_sync;

  localparam int C_SIZE = 4096;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [1:0]  width;
    logic [31:0] wdata;
    logic [1:0]  exp_resp;   // {err, ack}
    logic [31:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst0, rst3;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  wb_ram_sync_if #(.ADDR_W(32)) bus0 ();
  wb_ram_sync_if #(.ADDR_W(32)) bus3 ();

  wb_ram_sync #(.SIZE(C_SIZE), .ADDR_W(32), .WAIT_STATES(0)) u_dut0 (
    .iClk (clk),
    .iRst (rst0),
    .bus  (bus0)
  );

  wb_ram_sync #(.SIZE(C_SIZE), .ADDR_W(32), .WAIT_STATES(3)) u_dut3 (
    .iClk (clk),
    .iRst (rst3),
    .bus  (bus3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input bit cyc, input bit we, input logic [31:0] addr,
                       input logic [1:0] width, input logic [31:0] wdata);
    if (d == 0) begin
      bus0.cyc = cyc; bus0.stb = cyc; bus0.we = we;
      bus0.addr = addr; bus0.width = width; bus0.data_write = wdata;
    end else begin
      bus3.cyc = cyc; bus3.stb = cyc; bus3.we = we;
      bus3.addr = addr; bus3.width = width; bus3.data_write = wdata;
    end
  endtask

  function automatic logic [1:0] resp_of(input int d);
    return (d == 0) ? {bus0.err, bus0.ack} : {bus3.err, bus3.ack};
  endfunction

  function automatic logic [31:0] data_of(input int d);
    return (d == 0) ? bus0.data_read : bus3.data_read;
  endfunction

  // One complete bus access; called just after a rising edge with the DUT idle.
  task automatic access(input int d, input bit we, input logic [31:0] addr,
                        input logic [1:0] width, input logic [31:0] wdata,
                        output int lat, output logic [1:0] resp, output logic [31:0] rdata);
    lat = -1; resp = 2'b00; rdata = '0;
    drive(d, 1'b1, we, addr, width, wdata);
    for (int t = 1; t <= 40; t++) begin
      @(posedge clk); #1;
      if (resp_of(d) != 2'b00) begin
        lat = t; resp = resp_of(d); rdata = data_of(d);
        break;
      end
    end
    drive(d, 1'b0, 1'b0, '0, 2'b00, '0);
    @(posedge clk); #1;
    check("pulse_one_cycle", {30'd0, resp_of(d)}, 32'd0);
  endtask

  vec_t vecs[$];
  int   lat;
  logic [1:0]  resp;
  logic [31:0] rdata;
  int   ack_t[3];
  int   n_ack;
  int   consec;
  bit   prev_ack;
  bit   seen;

  initial begin
    rst0 = 1'b1; rst3 = 1'b1;
    drive(0, 1'b0, 1'b0, '0, 2'b00, '0);
    drive(3, 1'b0, 1'b0, '0, 2'b00, '0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack_err0", {30'd0, resp_of(0)}, 32'd0);
    check("reset_data0",    data_of(0), 32'd0);
    check("reset_ack_err3", {30'd0, resp_of(3)}, 32'd0);
    rst0 = 1'b0; rst3 = 1'b0;
    @(posedge clk); #1;

    // Table for the zero-wait-state instance.
    vecs.push_back('{1'b1, 32'h10, 2'b10, 32'hDEADBEEF, 2'b01, 32'h0});
    vecs.push_back('{1'b0, 32'h10, 2'b10, 32'h0,        2'b01, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 32'h13, 2'b00, 32'hFFFFFF5A, 2'b01, 32'h0});
    vecs.push_back('{1'b0, 32'h10, 2'b10, 32'h0,        2'b01, 32'h5AADBEEF});
    vecs.push_back('{1'b0, 32'h11, 2'b00, 32'h0,        2'b01, 32'h000000BE});
    vecs.push_back('{1'b0, 32'h12, 2'b01, 32'h0,        2'b01, 32'h00005AAD});
    vecs.push_back('{1'b1, 32'h20, 2'b11, 32'h01020304, 2'b01, 32'h0});
    vecs.push_back('{1'b1, 32'h20, 2'b01, 32'h9999ABCD, 2'b01, 32'h0});
    vecs.push_back('{1'b0, 32'h20, 2'b10, 32'h0,        2'b01, 32'h0102ABCD});
    vecs.push_back('{1'b0, 32'h22, 2'b01, 32'h0,        2'b01, 32'h00000102});
`ifdef WBRAM_ERR_EN
    vecs.push_back('{1'b1, 32'hFFC,  2'b10, 32'h55667788, 2'b01, 32'h0});
    vecs.push_back('{1'b1, 32'hFFE,  2'b10, 32'h11223344, 2'b10, 32'h0});
    vecs.push_back('{1'b0, 32'hFFC,  2'b10, 32'h0,        2'b01, 32'h55667788});
    vecs.push_back('{1'b0, 32'hFFF,  2'b01, 32'h0,        2'b10, 32'h0});
    vecs.push_back('{1'b0, 32'hFFF,  2'b00, 32'h0,        2'b01, 32'h00000055});
    vecs.push_back('{1'b0, 32'h2,    2'b10, 32'h0,        2'b10, 32'h0});
    vecs.push_back('{1'b1, 32'h11,   2'b01, 32'h0000FFFF, 2'b10, 32'h0});
    vecs.push_back('{1'b0, 32'h10,   2'b10, 32'h0,        2'b01, 32'h5AADBEEF});
    vecs.push_back('{1'b0, 32'h1010, 2'b00, 32'h0,        2'b10, 32'h0});
`else
    vecs.push_back('{1'b1, 32'hFFE,  2'b10, 32'h11223344, 2'b01, 32'h0});
    vecs.push_back('{1'b0, 32'hFFE,  2'b00, 32'h0,        2'b01, 32'h00000044});
    vecs.push_back('{1'b0, 32'hFFF,  2'b00, 32'h0,        2'b01, 32'h00000033});
    vecs.push_back('{1'b0, 32'h0,    2'b00, 32'h0,        2'b01, 32'h00000022});
    vecs.push_back('{1'b0, 32'h1,    2'b00, 32'h0,        2'b01, 32'h00000011});
    vecs.push_back('{1'b0, 32'hFFE,  2'b10, 32'h0,        2'b01, 32'h11223344});
    vecs.push_back('{1'b1, 32'h31,   2'b10, 32'hA1B2C3D4, 2'b01, 32'h0});
    vecs.push_back('{1'b0, 32'h33,   2'b01, 32'h0,        2'b01, 32'h0000A1B2});
    vecs.push_back('{1'b0, 32'h1010, 2'b10, 32'h0,        2'b01, 32'h5AADBEEF});
`endif

    foreach (vecs[i]) begin
      access(0, vecs[i].we, vecs[i].addr, vecs[i].width, vecs[i].wdata, lat, resp, rdata);
      check($sformatf("v%0d_resp", i),    {30'd0, resp}, {30'd0, vecs[i].exp_resp});
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd1);
      check($sformatf("v%0d_data", i),    rdata, vecs[i].exp_data);
    end

    // Three wait states: ack four cycles after the accept cycle.
    access(3, 1'b1, 32'h40, 2'b10, 32'hCAFEF00D, lat, resp, rdata);
    check("ws3_write_resp", {30'd0, resp}, 32'd1);
    check("ws3_write_latency", 32'(lat), 32'd4);
    access(3, 1'b0, 32'h40, 2'b10, 32'h0, lat, resp, rdata);
    check("ws3_read_latency", 32'(lat), 32'd4);
    check("ws3_read_data", rdata, 32'hCAFEF00D);

    // Abort: cyc dropped in cycle 2 of a write.
    drive(3, 1'b1, 1'b1, 32'h40, 2'b10, 32'h12345678);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(3, 1'b0, 1'b0, '0, 2'b00, '0);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (resp_of(3) != 2'b00) seen = 1'b1;
    end
    check("abort_no_ack", {31'd0, seen}, 32'd0);
    access(3, 1'b0, 32'h40, 2'b10, 32'h0, lat, resp, rdata);
    check("abort_old_data", rdata, 32'hCAFEF00D);

    // Back-to-back reads with stb held throughout.
    drive(3, 1'b1, 1'b0, 32'h40, 2'b10, 32'h0);
    n_ack = 0; consec = 0; prev_ack = 1'b0;
    for (int t = 1; t <= 60 && n_ack < 3; t++) begin
      @(posedge clk); #1;
      if (bus3.ack) begin
        if (prev_ack) consec++;
        ack_t[n_ack] = t;
        check($sformatf("b2b_data%0d", n_ack), bus3.data_read, 32'hCAFEF00D);
        n_ack++;
      end
      prev_ack = bus3.ack;
    end
    drive(3, 1'b0, 1'b0, '0, 2'b00, '0);
    @(posedge clk); #1;
    check("b2b_ack_count", 32'(n_ack), 32'd3);
    if (n_ack == 3) begin
      check("b2b_first", 32'(ack_t[0]), 32'd4);
      check("b2b_gap1", 32'(ack_t[1] - ack_t[0]), 32'd5);
      check("b2b_gap2", 32'(ack_t[2] - ack_t[1]), 32'd5);
    end
    check("b2b_no_consecutive", 32'(consec), 32'd0);

    // Reset while a write waits.
    drive(3, 1'b1, 1'b1, 32'h40, 2'b10, 32'h0BADC0DE);
    @(posedge clk); #1;
    rst3 = 1'b1;
    drive(3, 1'b0, 1'b0, '0, 2'b00, '0);
    @(posedge clk); #1;
    check("rst_wait_resp", {30'd0, resp_of(3)}, 32'd0);
    check("rst_wait_data", data_of(3), 32'd0);
    rst3 = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (resp_of(3) != 2'b00) seen = 1'b1;
    end
    check("rst_no_late_ack", {31'd0, seen}, 32'd0);
    access(3, 1'b0, 32'h40, 2'b10, 32'h0, lat, resp, rdata);
    check("rst_data_retained", rdata, 32'hCAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
